// File: rtl/qspi_prog_pkg.sv
// Shared constants and state encodings for the QSPI flash page writer.
package qspi_prog_pkg;

  // Flash opcodes as issued to qspi_mem_controller.
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_SE   = 8'hD8;
  localparam logic [7:0] CMD_PP   = 8'h02;

  localparam int PAGE_BYTES = 256;
  localparam int PAGE_BITS  = PAGE_BYTES * 8;
  localparam int PP_DATA_W  = 2072;  // 24-bit address + one 256-byte page

  // Page sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ERASE_WREN,
    ST_ERASE,
    ST_PROG_WREN,
    ST_PROG,
    ST_NEXT,
    ST_FINISH
  } wr_state_e;

  // Controller handshake states.
  typedef enum logic [1:0] {
    IS_IDLE,
    IS_ACK,
    IS_DONE
  } iss_state_e;

endpackage

// File: rtl/qspi_cmd_issuer.sv
// Runs one trigger/ack/complete handshake with qspi_mem_controller per go request.
// cmd and data are captured with the trigger, so they stay stable until completion.
module qspi_cmd_issuer
  import qspi_prog_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go_i,
  input  logic [7:0]           cmd_i,
  input  logic [PP_DATA_W-1:0] data_i,
  output logic                 cmd_done_o,
  output logic                 cmd_err_o,
  output logic                 qc_trigger_o,
  output logic [7:0]           qc_cmd_o,
  output logic [PP_DATA_W-1:0] qc_data_send_o,
  input  logic                 qc_busy_i,
  input  logic                 qc_error_i
);

  iss_state_e             state_q, state_d;
  logic                   trigger_q, trigger_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [PP_DATA_W-1:0]   data_q, data_d;

  // Handshake next-state: launch when the controller is idle, then track ack and completion.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d    = state_q;
    trigger_d  = 1'b0;
    cmd_d      = cmd_q;
    data_d     = data_q;
    cmd_done_o = 1'b0;
    cmd_err_o  = 1'b0;
    case (state_q)
      IS_IDLE: begin
        // The busy check also covers a controller still working after a reset of this block.
        if (go_i && !qc_busy_i) begin
          trigger_d = 1'b1;
          cmd_d     = cmd_i;
          data_d    = data_i;
          state_d   = IS_ACK;
        end
      end
      IS_ACK: begin
        if (qc_busy_i) state_d = IS_DONE;
      end
      IS_DONE: begin
        // Completion is reported in the same cycle busy falls to keep the 2-cycle turnaround.
        if (!qc_busy_i) begin
          cmd_done_o = 1'b1;
          cmd_err_o  = qc_error_i;
          state_d    = IS_IDLE;
        end
      end
      default: state_d = IS_IDLE;
    endcase
  end

  // Handshake registers; trigger is high for exactly the first cycle of IS_ACK.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= IS_IDLE;
      trigger_q <= 1'b0;
      cmd_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      trigger_q <= trigger_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
    end
  end

  assign qc_trigger_o   = trigger_q;
  assign qc_cmd_o       = cmd_q;
  assign qc_data_send_o = data_q;

endmodule

// File: rtl/qspi_flash_page_writer.sv
// Buffers a byte stream into 256-byte pages and programs each page into NOR flash,
// erasing a sector first when a page opens it.
module qspi_flash_page_writer
  import qspi_prog_pkg::*;
#(
  parameter bit ERASE_EN    = 1'b1,
  parameter int SECTOR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [23:0]          base_addr,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 qc_trigger,
  output logic [7:0]           qc_cmd,
  output logic [PP_DATA_W-1:0] qc_data_send,
  input  logic                 qc_busy,
  input  logic                 qc_error,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          pages_written
);

  wr_state_e              state_q, state_d;
  logic [23:0]            addr_q, addr_d;
  logic [7:0]             idx_q, idx_d;
  logic                   last_q, last_d;
  logic                   error_q, error_d;
  logic [15:0]            pages_q, pages_d;
  logic [PAGE_BITS-1:0]   buf_q, buf_d;

  logic                   issue_go;
  logic [7:0]             issue_cmd;
  logic [PP_DATA_W-1:0]   issue_data;
  logic                   cmd_done;
  logic                   cmd_err;
  logic                   sector_open;
  logic [10:0]            wr_lsb;

  // Byte k of the page sits at [2047-8k -: 8], i.e. LSB (255-k)*8.
  assign wr_lsb      = {~idx_q, 3'b000};
  assign sector_open = ERASE_EN && (addr_q[SECTOR_BITS-1:0] == '0);

  // Page sequencer: fill, optional erase, program, advance.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    last_d     = last_q;
    error_d    = error_q;
    pages_d    = pages_q;
    buf_d      = buf_q;
    issue_go   = 1'b0;
    issue_cmd  = CMD_WREN;
    issue_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = {base_addr[23:8], 8'h00};
          error_d = 1'b0;
          pages_d = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          buf_d   = '1;  // unwritten bytes of a short page go out as 0xFF
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (s_valid) begin
          buf_d[wr_lsb +: 8] = s_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'hFF || s_last) begin
            last_d  = s_last;
            state_d = sector_open ? ST_ERASE_WREN : ST_PROG_WREN;
          end
        end
      end
      ST_ERASE_WREN: begin
        issue_go = 1'b1;
        if (cmd_done) state_d = ST_ERASE;  // WREN errors are not fatal
      end
      ST_ERASE: begin
        issue_go   = 1'b1;
        issue_cmd  = CMD_SE;
        issue_data = {{(PP_DATA_W-24){1'b0}}, addr_q};
        if (cmd_done) begin
          if (cmd_err) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_PROG_WREN;
          end
        end
      end
      ST_PROG_WREN: begin
        issue_go = 1'b1;
        if (cmd_done) state_d = ST_PROG;
      end
      ST_PROG: begin
        issue_go   = 1'b1;
        issue_cmd  = CMD_PP;
        issue_data = {addr_q, buf_q};
        if (cmd_done) begin
          if (cmd_err) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (pages_q != 16'hFFFF) pages_d = pages_q + 16'd1;
        if (last_q) begin
          state_d = ST_FINISH;
        end else if (addr_q == 24'hFFFF00) begin
          error_d = 1'b1;  // next page would wrap to address 0
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + 24'd256;
          idx_d   = '0;
          buf_d   = '1;
          state_d = ST_FILL;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
      pages_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      error_q <= error_d;
      pages_q <= pages_d;
    end
  end

  // Page buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the page buffer; it is preset to 0xFF whenever a page opens.
    buf_q <= buf_d;
  end

  qspi_cmd_issuer u_issuer (
    .clk            (clk),
    .reset          (reset),
    .go_i           (issue_go),
    .cmd_i          (issue_cmd),
    .data_i         (issue_data),
    .cmd_done_o     (cmd_done),
    .cmd_err_o      (cmd_err),
    .qc_trigger_o   (qc_trigger),
    .qc_cmd_o       (qc_cmd),
    .qc_data_send_o (qc_data_send),
    .qc_busy_i      (qc_busy),
    .qc_error_i     (qc_error)
  );

  assign s_ready       = (state_q == ST_FILL);
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done          = (state_q == ST_FINISH);
  assign error         = error_q;
  assign pages_written = pages_q;

endmodule

// File: doc/qspi_flash_page_writer.md
Name: qspi_flash_page_writer

Overview:
- Sequences `qspi_mem_controller` to program an arbitrary-length byte stream into NOR flash.
- Buffers the incoming stream into 256-byte pages. For each page it issues WREN+SE when the page opens a 64 KiB sector, then WREN+PP.
- Reports completion, page count and errors.
- Sits between a host or UART loader and the controller's trigger/cmd/data_send/busy/error interface. It is the only driver of that interface.

Parameters:
- ERASE_EN, 1: 1 = erase each sector whose first page is programmed; 0 = never erase.
- SECTOR_BITS, 16: log2 of sector size. The page address opens a sector when addr[SECTOR_BITS-1:0]==0.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  one-cycle pulse; accepted only in IDLE; latches base_addr
- base_addr  in  24  flash start address; bits [7:0] ignored and forced to 0
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_last  in  1  qualifies the final byte of the job
- s_ready  out  1  byte accepted when s_valid&&s_ready
- qc_trigger  out  1  to controller trigger
- qc_cmd  out  8  to controller cmd
- qc_data_send  out  2072  to controller data_send
- qc_busy  in  1  from controller busy
- qc_error  in  1  from controller error
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end (success or error)
- error  out  1  sticky until next accepted start
- pages_written  out  16  pages successfully programmed in the current job

Behaviour:
- Reset is synchronous and active-high, applied on clk. All outputs reset to 0; the FSM enters IDLE.
- On reset mid-job, the page buffer contents are don't-care. The controller is not aborted; the first start after reset waits for qc_busy==0.
- FSM states: IDLE, FILL, ERASE_WREN, ERASE, PROG_WREN, PROG, NEXT, FINISH.
- IDLE:
  - start latches addr=base_addr&~0xFF, clears error, pages_written and idx.
  - Sets busy=1 and goes to FILL.
  - start in any other state is ignored.
- FILL:
  - s_ready=1. Each accepted byte is written to buf[idx]; idx increments.
  - The page closes on acceptance of byte idx==255, or of any byte with s_last=1.
  - On close, go to ERASE_WREN if ERASE_EN && addr[SECTOR_BITS-1:0]==0, else PROG_WREN. s_ready drops in the close cycle's successor.
  - Unwritten bytes of a partial page are transmitted as 0xFF.
- Command issue, used by every *_WREN/ERASE/PROG state through the sub-module:
  - Wait for qc_busy==0.
  - Drive qc_trigger=1 for exactly one cycle, with qc_cmd and qc_data_send stable from that cycle until completion.
  - Wait for qc_busy==1 (ack), then qc_busy==0 (complete).
  - Sample qc_error in the completion cycle.
- Command encoding:
  - WREN: 0x06, data don't-care.
  - SE: 0xD8, qc_data_send[23:0]=addr.
  - PP: 0x02, qc_data_send[2071:2048]=addr, byte k at [2047-8k -: 8].
- Transitions:
  - ERASE_WREN -> ERASE -> PROG_WREN -> PROG -> NEXT.
  - qc_error=1 on SE or PP completion sets error=1 and goes to FINISH. WREN errors are ignored.
- NEXT:
  - pages_written+1.
  - If the closed page had s_last: go to FINISH.
  - Else if addr==0xFFFF00: set error=1 (address wrap) and go to FINISH.
  - Else addr+=256, idx=0, go to FILL.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- s_last on the 256th byte closes one full page and ends the job. No empty page follows.
- s_valid with s_ready=0 is held by the source; no bytes are dropped.
- Latency:
  - Byte accept to WREN trigger: 2 cycles.
  - Controller completion to next trigger: 2 cycles.
  - PP completion to done for the last page: 2 cycles.
- pages_written saturates at 0xFFFF.

Decomposition:
- Package qspi_prog_pkg: CMD_WREN/CMD_SE/CMD_PP constants (mirroring the defs.vh values), PAGE_BYTES=256, PP_DATA_W=2072, FSM state enum.
- Sub-module qspi_cmd_issuer:
  - Inputs: go, cmd, data from the sequencer.
  - Owns the trigger/ack/complete handshake.
  - Returns cmd_done and cmd_err pulses.

Test Plan:
- Full aligned page: start with base_addr=0x010000, stream 256 bytes 0x00..0xFF, last on byte 255.
  - Controller model sees WREN, SE(0x010000), WREN, PP(0x010000) in order.
  - PP data byte 0=0x00, byte 255=0xFF.
  - done pulse, pages_written=1, error=0.
- Multi-page, no erase boundary: base_addr=0x020300, 600 bytes.
  - PP at 0x020300, 0x020400, 0x020500.
  - Third page bytes 88..255 = 0xFF.
  - No SE issued; pages_written=3.
- Erase error: controller model asserts qc_error at SE completion.
  - No PP issued, error=1, done pulse, pages_written=0.
  - A subsequent start clears error.
- Address wrap: base_addr=0xFFFF00, 300 bytes.
  - One PP at 0xFFFF00, then error=1, done, pages_written=1.
  - s_ready stays 0 for the remaining bytes.
- Backpressure and busy: slow controller (busy 50 cycles per command), s_valid held high.
  - s_ready=0 outside FILL.
  - Exactly one qc_trigger cycle per command; trigger is never asserted while qc_busy=1.
- Reset mid-PP: assert reset while the controller is busy.
  - All outputs read 0 the next cycle.
  - A new start waits for qc_busy==0 before its first trigger.
